// File: rtl/multi_lane_cordic_stage.sv
// multi_lane_cordic_stage
// Takes N_CH packed operands, hands them one per cycle to a shared CORDIC
// pipeline, and gathers the in-order returns back into packed result and
// squared words. Collection runs in parallel with issue, so a short pipeline
// can start returning before the last channel has gone out.
module multi_lane_cordic_stage #(
  parameter int N_CH              = 4,
  parameter int CORDIC_DATA_WIDTH = 22,
  parameter int FLOAT_DATA_WIDTH  = 32,
  parameter int DEFAULT_INPUT     = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clk_en,
  input  logic                                  start,
  input  logic [N_CH*CORDIC_DATA_WIDTH-1:0]     x_in,
  input  logic [N_CH*FLOAT_DATA_WIDTH-1:0]      sq_in,
  output logic                                  busy,
  output logic [CORDIC_DATA_WIDTH-1:0]          pipe_target,
  output logic [FLOAT_DATA_WIDTH-1:0]           pipe_square,
  output logic                                  pipe_start,
  input  logic [CORDIC_DATA_WIDTH-1:0]          pipe_result,
  input  logic [FLOAT_DATA_WIDTH-1:0]           pipe_squared,
  input  logic                                  pipe_valid,
  output logic [N_CH*CORDIC_DATA_WIDTH-1:0]     result,
  output logic [N_CH*FLOAT_DATA_WIDTH-1:0]      squared,
  output logic                                  valid,
  output logic                                  err
);

  localparam int CW = $clog2(N_CH) + 1;
  localparam int XW = N_CH * CORDIC_DATA_WIDTH;
  localparam int SW = N_CH * FLOAT_DATA_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, COLLECT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] issue_idx, issue_idx_nxt;
  logic [CW-1:0] collect_idx, collect_idx_nxt;
  logic [XW-1:0] x_lat;
  logic [SW-1:0] sq_lat;
  logic          accept, capture, last_issue, last_capture;

  // Next-state and counter advance; counters saturate at the last channel
  always_comb begin
    accept          = (state == IDLE) && start;
    capture         = (state != IDLE) && pipe_valid;
    last_issue      = (state == ISSUE) && (issue_idx == LAST);
    last_capture    = capture && (collect_idx == LAST);
    state_nxt       = state;
    issue_idx_nxt   = issue_idx;
    collect_idx_nxt = collect_idx;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt       = ISSUE;
          issue_idx_nxt   = '0;
          collect_idx_nxt = '0;
        end
      end
      ISSUE: begin
        if (!last_issue) issue_idx_nxt = issue_idx + CW'(1);
        if (capture && !last_capture) collect_idx_nxt = collect_idx + CW'(1);
        if (last_capture) state_nxt = IDLE;
        else if (last_issue) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (capture && !last_capture) collect_idx_nxt = collect_idx + CW'(1);
        if (last_capture) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Issue port: the latched channel selected by issue_idx while issuing, idle value otherwise
  always_comb begin
    pipe_start  = (state == ISSUE);
    pipe_target = CORDIC_DATA_WIDTH'(DEFAULT_INPUT);
    pipe_square = FLOAT_DATA_WIDTH'(DEFAULT_INPUT);
    if (state == ISSUE) begin
      for (int k = 0; k < N_CH; k++) begin
        if (issue_idx == CW'(k)) begin
          pipe_target = x_lat[k*CORDIC_DATA_WIDTH +: CORDIC_DATA_WIDTH];
          pipe_square = sq_lat[k*FLOAT_DATA_WIDTH +: FLOAT_DATA_WIDTH];
        end
      end
    end
  end

  // Operand capture on an accepted start only, so a start while busy cannot disturb them
  always_ff @(posedge clk) begin
    if (rst && clk_en && accept) begin
      x_lat  <= x_in;
      sq_lat <= sq_in;
    end
  end

  // Control state, status flags and result gathering
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      issue_idx   <= '0;
      collect_idx <= '0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      err         <= 1'b0;
      result      <= '0;
      squared     <= '0;
    end else if (clk_en) begin
      state       <= state_nxt;
      issue_idx   <= issue_idx_nxt;
      collect_idx <= collect_idx_nxt;
      busy        <= (state_nxt != IDLE);
      valid       <= last_capture;
      // A return with nothing outstanding is latched until the next accepted start
      if ((state == IDLE) && pipe_valid) err <= 1'b1;
      else if (accept) err <= 1'b0;
      if (capture) begin
        for (int k = 0; k < N_CH; k++) begin
          if (collect_idx == CW'(k)) begin
            result[k*CORDIC_DATA_WIDTH +: CORDIC_DATA_WIDTH] <= pipe_result;
            squared[k*FLOAT_DATA_WIDTH +: FLOAT_DATA_WIDTH]  <= pipe_squared;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_lane_cordic_stage.sv
// Bench for multi_lane_cordic_stage: drives transactions into the block,
// emulates a 3-deep echoing CORDIC pipeline, and scores gathered results
// against the operands that were launched.
module tb_multi_lane_cordic_stage;

  localparam int N   = 4;
  localparam int CDW = 22;
  localparam int FDW = 32;
  localparam int XW  = N * CDW;
  localparam int SW  = N * FDW;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst, clk_en, start;
  logic [XW-1:0] x_in;
  logic [SW-1:0] sq_in;
  logic          busy, pipe_start, pipe_valid, valid, err;
  logic [CDW-1:0] pipe_target, pipe_result;
  logic [FDW-1:0] pipe_square, pipe_squared;
  logic [XW-1:0] result;
  logic [SW-1:0] squared;

  // Pipeline emulation and spurious-return injection
  logic [LAT-1:0] pl_v = '0;
  logic [CDW-1:0] pl_r [LAT];
  logic [FDW-1:0] pl_s [LAT];
  logic           inj_v;
  logic [CDW-1:0] inj_r;
  logic [FDW-1:0] inj_s;

  // Scoreboard state
  logic [XW-1:0]  exp_r_q [$];
  logic [SW-1:0]  exp_s_q [$];
  logic [CDW-1:0] iss_t_q [$];
  logic [FDW-1:0] iss_s_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int n_issues = 0;
  int cyc = 0;
  int last_valid_cyc = 0;
  int acc_cyc = 0;
  logic edge_en = 1'b0;

  multi_lane_cordic_stage #(
    .N_CH(N), .CORDIC_DATA_WIDTH(CDW), .FLOAT_DATA_WIDTH(FDW), .DEFAULT_INPUT(0)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start),
    .x_in(x_in), .sq_in(sq_in), .busy(busy),
    .pipe_target(pipe_target), .pipe_square(pipe_square), .pipe_start(pipe_start),
    .pipe_result(pipe_result), .pipe_squared(pipe_squared), .pipe_valid(pipe_valid),
    .result(result), .squared(squared), .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  // Shared pipeline: fixed latency, stalls with clk_en, returns operands unchanged
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    edge_en <= clk_en;
    if (clk_en) begin
      pl_v    <= {pl_v[LAT-2:0], (pipe_start === 1'b1)};
      pl_r[0] <= pipe_target;
      pl_s[0] <= pipe_square;
      for (int i = 1; i < LAT; i++) begin
        pl_r[i] <= pl_r[i-1];
        pl_s[i] <= pl_s[i-1];
      end
    end
  end

  assign pipe_valid   = pl_v[LAT-1] | inj_v;
  assign pipe_result  = inj_v ? inj_r : pl_r[LAT-1];
  assign pipe_squared = inj_v ? inj_s : pl_s[LAT-1];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic [XW-1:0] rand_x();
    logic [XW-1:0] v;
    for (int k = 0; k < N; k++) v[k*CDW +: CDW] = CDW'($urandom);
    return v;
  endfunction

  function automatic logic [SW-1:0] rand_s();
    logic [SW-1:0] v;
    for (int k = 0; k < N; k++) v[k*FDW +: FDW] = $urandom;
    return v;
  endfunction

  // Reference: the echo pipeline returns each operand, and issue order is channel order
  task automatic push_exp(input logic [XW-1:0] x, input logic [SW-1:0] s);
    exp_r_q.push_back(x);
    exp_s_q.push_back(s);
    for (int k = 0; k < N; k++) begin
      iss_t_q.push_back(x[k*CDW +: CDW]);
      iss_s_q.push_back(s[k*FDW +: FDW]);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic launch(input logic [XW-1:0] x, input logic [SW-1:0] s);
    push_exp(x, s);
    start = 1'b1;
    x_in  = x;
    sq_in = s;
    @(posedge clk); #1;
    start   = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_drain(input int budget, input bit rnd_stall);
    int i;
    for (i = 0; i < budget; i++) begin
      if (exp_r_q.size() == 0 && iss_t_q.size() == 0) break;
      @(posedge clk); #1;
      if (rnd_stall) clk_en = ($urandom_range(0, 3) != 0);
    end
    clk_en = 1'b1;
    if (i == budget) timeout_fail("drain");
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (valid) break;
    end
    if (i == budget) timeout_fail("wait_valid");
  endtask

  // Output monitor: one scoreboard pop per enabled valid cycle
  initial forever begin
    logic [XW-1:0] er;
    logic [SW-1:0] es;
    @(negedge clk);
    if (valid && edge_en) begin
      last_valid_cyc = cyc;
      if (exp_r_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: result=%0h, no transaction outstanding", result);
      end else begin
        er = exp_r_q.pop_front();
        es = exp_s_q.pop_front();
        chk("result", 128'(result), 128'(er));
        chk("squared", 128'(squared), 128'(es));
      end
    end
  end

  // Issue monitor: each enabled pipe_start must carry the next channel in order
  initial forever begin
    logic [CDW-1:0] et;
    logic [FDW-1:0] esq;
    @(negedge clk);
    if (rst && clk_en && pipe_start) begin
      n_issues++;
      if (iss_t_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL extra_issue: target=%0h, expected no issue", pipe_target);
      end else begin
        et  = iss_t_q.pop_front();
        esq = iss_s_q.pop_front();
        chk("pipe_target", 128'(pipe_target), 128'(et));
        chk("pipe_square", 128'(pipe_square), 128'(esq));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XW-1:0] xa, xb, rsave;
    logic [SW-1:0] sa, sb, ssave;
    int bc, base_issues;

    rst = 1'b0; clk_en = 1'b0; start = 1'b0;
    x_in = '0; sq_in = '0;
    inj_v = 1'b0; inj_r = '0; inj_s = '0;

    // Reset with clk_en low must still clear everything
    repeat (5) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_valid", 128'(valid), 128'(0));
    chk("rst_pipe_start", 128'(pipe_start), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_result", 128'(result), 128'(0));
    chk("rst_squared", 128'(squared), 128'(0));
    chk("rst_pipe_target", 128'(pipe_target), 128'(0));
    chk("rst_pipe_square", 128'(pipe_square), 128'(0));
    rst = 1'b1; clk_en = 1'b1;
    @(posedge clk); #1;

    // Basic: operands 1..4, busy for 7 cycles, valid 7 edges after accept
    xa = {CDW'(4), CDW'(3), CDW'(2), CDW'(1)};
    sa = rand_s();
    base_issues = n_issues;
    launch(xa, sa);
    chk("latency_pipe_start", 128'(pipe_start), 128'(1));
    chk("first_target", 128'(pipe_target), 128'(1));
    bc = 0;
    for (int i = 0; i < 50; i++) begin
      if (!busy) break;
      bc++;
      @(posedge clk); #1;
    end
    chk("busy_cycles", 128'(bc), 128'(7));
    wait_drain(50, 1'b0);
    chk("issue_count", 128'(n_issues - base_issues), 128'(N));
    chk("valid_latency", 128'(last_valid_cyc - acc_cyc), 128'(7));
    repeat (3) @(posedge clk);
    #1;
    chk("result_hold", 128'(result), 128'(xa));

    // Stall two cycles while channel 1 is presented
    xa = rand_x(); sa = rand_s();
    launch(xa, sa);
    @(posedge clk); #1;
    chk("stall_pre_target", 128'(pipe_target), 128'(xa[CDW +: CDW]));
    clk_en = 1'b0;
    @(negedge clk);
    chk("stall_target_a", 128'(pipe_target), 128'(xa[CDW +: CDW]));
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_target_b", 128'(pipe_target), 128'(xa[CDW +: CDW]));
    @(posedge clk); #1;
    clk_en = 1'b1;
    wait_drain(50, 1'b0);
    chk("stall_valid_latency", 128'(last_valid_cyc - acc_cyc), 128'(9));

    // Back-to-back: new start in the valid cycle
    xa = rand_x(); sa = rand_s();
    launch(xa, sa);
    wait_valid(50);
    xb = {CDW'(8), CDW'(7), CDW'(6), CDW'(5)};
    sb = rand_s();
    push_exp(xb, sb);
    start = 1'b1; x_in = xb; sq_in = sb;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_pipe_start", 128'(pipe_start), 128'(1));
    chk("b2b_busy", 128'(busy), 128'(1));
    wait_drain(50, 1'b0);

    // Start while busy with different operands is ignored
    xa = rand_x(); sa = rand_s();
    launch(xa, sa);
    @(posedge clk); #1;
    start = 1'b1; x_in = ~xa; sq_in = ~sa;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain(50, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_start_ignored", 128'(busy), 128'(0));

    // Mid-transaction reset after two issues
    xa = rand_x(); sa = rand_s();
    launch(xa, sa);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_r_q.delete(); exp_s_q.delete();
    iss_t_q.delete(); iss_s_q.delete();
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_valid", 128'(valid), 128'(0));
    chk("abort_pipe_start", 128'(pipe_start), 128'(0));
    chk("abort_pipe_target", 128'(pipe_target), 128'(0));
    chk("abort_result", 128'(result), 128'(0));
    chk("abort_squared", 128'(squared), 128'(0));
    chk("abort_err", 128'(err), 128'(0));
    repeat (6) @(posedge clk);
    #1;
    chk("late_return_err", 128'(err), 128'(1));
    chk("late_return_valid", 128'(valid), 128'(0));
    xa = rand_x(); sa = rand_s();
    launch(xa, sa);
    chk("start_clears_err", 128'(err), 128'(0));
    wait_drain(50, 1'b0);

    // Spurious return in IDLE
    chk("pre_spur_err", 128'(err), 128'(0));
    rsave = result; ssave = squared;
    inj_v = 1'b1; inj_r = ~rsave[CDW-1:0]; inj_s = ~ssave[FDW-1:0];
    @(posedge clk); #1;
    inj_v = 1'b0;
    chk("spur_err", 128'(err), 128'(1));
    chk("spur_result", 128'(result), 128'(rsave));
    chk("spur_squared", 128'(squared), 128'(ssave));
    chk("spur_valid", 128'(valid), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("err_sticky", 128'(err), 128'(1));

    // Randomized transactions with random stalls
    for (int t = 0; t < 12; t++) begin
      xa = rand_x(); sa = rand_s();
      launch(xa, sa);
      wait_drain(400, 1'b1);
    end
    chk("final_err", 128'(err), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
